// File: rtl/game_pkg.sv
// Shared Connect-4 definitions: piece codes, board sizing and the
// win-check controller state encoding.
package game_pkg;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    localparam int unsigned COMBO_BITS = 452;
    localparam int unsigned MAX_MOVES  = 42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DECIDE,
        ST_OVER
    } ctrl_state_t;

    // A recognizer code counts as a win only for a real colour; 11 is illegal.
    function automatic logic is_four(input logic [1:0] code);
        return (code == RED) || (code == YELLOW);
    endfunction

endpackage

// File: rtl/win_check_controller_cycle_timer.sv
// Loadable 8-bit down-counter with a zero flag; times the LOAD and SCAN phases.
module cycle_timer
    import game_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/win_check_controller.sv
// Turn and win-check sequencer: gates the 2-bit sequence recognizer per move
// and tracks player, move count, winner and draw.
module win_check_controller
    import game_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 2,
    parameter int unsigned SCAN_CYCLES = COMBO_BITS / 2 + 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    output logic       move_ready,
    output logic       rec_enable,
    input  logic [1:0] rec_out,
    output logic [1:0] current_player,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       draw,
    output logic [5:0] move_count,
    output logic       busy
);

    ctrl_state_t state, next_state;

    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_dec;
    logic       timer_done;
    logic       accept;
    logic       rec_win;
    logic       board_full;

    assign rec_win    = is_four(rec_out);
    assign board_full = (move_count == 6'(MAX_MOVES));
    assign move_ready = (state == ST_IDLE) && !game_over;
    assign accept     = move_valid && move_ready && !new_game;
    assign busy       = (state == ST_LOAD) || (state == ST_SCAN) || (state == ST_DECIDE);

    cycle_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (new_game),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .done       (timer_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_dec   = 1'b0;
        rec_enable  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state  = ST_LOAD;
                    timer_load  = 1'b1;
                    timer_value = 8'(LOAD_CYCLES - 1);
                end
            end
            ST_LOAD: begin
                if (timer_done) begin
                    next_state  = ST_SCAN;
                    timer_load  = 1'b1;
                    timer_value = 8'(SCAN_CYCLES - 1);
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_SCAN: begin
                rec_enable = 1'b1;
                // Recognizer win states are sticky, so the first win ends the scan.
                if (rec_win || timer_done) begin
                    next_state = ST_DECIDE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_DECIDE: begin
                next_state = (rec_win || board_full) ? ST_OVER : ST_IDLE;
            end
            ST_OVER: begin
                next_state = ST_OVER;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (new_game) begin
            next_state = ST_IDLE;
            timer_load = 1'b0;
            timer_dec  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            current_player <= RED;
            winner         <= EMPTY;
            game_over      <= 1'b0;
            draw           <= 1'b0;
            move_count     <= '0;
        end else if (new_game) begin
            current_player <= RED;
            winner         <= EMPTY;
            game_over      <= 1'b0;
            draw           <= 1'b0;
            move_count     <= '0;
        end else begin
            if (accept && !board_full) begin
                move_count <= move_count + 6'd1;
            end
            // rec_out is still valid in DECIDE; winner outranks a full board.
            if (state == ST_DECIDE) begin
                if (rec_win) begin
                    winner    <= rec_out;
                    game_over <= 1'b1;
                end else if (board_full) begin
                    draw      <= 1'b1;
                    game_over <= 1'b1;
                end else begin
                    current_player <= (current_player == RED) ? YELLOW : RED;
                end
            end
        end
    end

endmodule

// File: tb/tb_win_check_controller.sv
// Directed self-checking bench for win_check_controller.
module tb_win_check_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic       move_ready;
    logic       rec_enable;
    logic [1:0] rec_out;
    logic [1:0] current_player;
    logic [1:0] winner;
    logic       game_over;
    logic       draw;
    logic [5:0] move_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    win_check_controller #(.LOAD_CYCLES(2), .SCAN_CYCLES(228)) dut (
        .clock          (clock),
        .reset          (reset),
        .new_game       (new_game),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .rec_enable     (rec_enable),
        .rec_out        (rec_out),
        .current_player (current_player),
        .winner         (winner),
        .game_over      (game_over),
        .draw           (draw),
        .move_count     (move_count),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Accepts one move and follows the check to completion, sampling at negedges.
    task automatic play_move(input logic [1:0] base_code, input logic [1:0] win_code,
                             input int win_at, input bit stall,
                             output int low_cnt, output int high_cnt,
                             output int decide_cnt, output bit timeout);
        low_cnt = 0; high_cnt = 0; decide_cnt = 0; timeout = 1'b1;
        rec_out = base_code;
        move_valid = 1'b1;
        @(negedge clock);
        if (!stall) move_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            if (rec_enable) begin
                high_cnt++;
                if (win_at != 0 && high_cnt == win_at) rec_out = win_code;
            end else if (high_cnt == 0) begin
                low_cnt++;
            end else begin
                decide_cnt++;
                move_valid = 1'b0;
            end
            @(negedge clock);
        end
        move_valid = 1'b0;
        rec_out = 2'b00;
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; rec_out = 2'b00;
        @(negedge clock);
        checks++; if (rec_enable !== 1'b0) begin errors++; $display("FAIL reset_rec_enable got %0h want 0", rec_enable); end
        checks++; if (current_player !== 2'b01) begin errors++; $display("FAIL reset_player got %0h want 1", current_player); end
        checks++; if (winner !== 2'b00 || game_over !== 1'b0 || draw !== 1'b0) begin errors++; $display("FAIL reset_result got w=%0h go=%0h d=%0h want 0 0 0", winner, game_over, draw); end
        checks++; if (move_count !== 6'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_count_busy got %0d/%0h want 0/0", move_count, busy); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL reset_move_ready got %0h want 1", move_ready); end
    endtask

    task automatic test_single_move();
        int lo, hi, dc; bit to;
        start_new_game();
        play_move(2'b00, 2'b00, 0, 1'b0, lo, hi, dc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %0h want 0", to); end
        checks++; if (lo != 2) begin errors++; $display("FAIL single_load_cycles got %0d want 2", lo); end
        checks++; if (hi != 228) begin errors++; $display("FAIL single_scan_cycles got %0d want 228", hi); end
        checks++; if (dc != 1) begin errors++; $display("FAIL single_decide_cycles got %0d want 1", dc); end
        checks++; if (current_player !== 2'b10) begin errors++; $display("FAIL single_player got %0h want 2", current_player); end
        checks++; if (move_count !== 6'd1 || winner !== 2'b00) begin errors++; $display("FAIL single_count_winner got %0d/%0h want 1/0", move_count, winner); end
        checks++; if (move_ready !== 1'b1 || game_over !== 1'b0) begin errors++; $display("FAIL single_ready got %0h/%0h want 1/0", move_ready, game_over); end
    endtask

    task automatic test_early_win();
        int lo, hi, dc; bit to;
        start_new_game();
        play_move(2'b00, 2'b10, 37, 1'b0, lo, hi, dc, to);
        checks++; if (to !== 1'b0 || hi != 37 || dc != 1) begin errors++; $display("FAIL early_scan got to=%0h hi=%0d dc=%0d want 0 37 1", to, hi, dc); end
        checks++; if (winner !== 2'b10 || game_over !== 1'b1) begin errors++; $display("FAIL early_result got w=%0h go=%0h want 2 1", winner, game_over); end
        checks++; if (move_ready !== 1'b0 || draw !== 1'b0) begin errors++; $display("FAIL early_ready got r=%0h d=%0h want 0 0", move_ready, draw); end
        move_valid = 1'b1;
        repeat (3) @(negedge clock);
        move_valid = 1'b0;
        checks++; if (move_count !== 6'd1 || busy !== 1'b0 || winner !== 2'b10) begin errors++; $display("FAIL early_ignore got c=%0d b=%0h w=%0h want 1 0 2", move_count, busy, winner); end
        start_new_game();
        checks++; if (winner !== 2'b00 || game_over !== 1'b0 || move_count !== 6'd0 || current_player !== 2'b01 || move_ready !== 1'b1) begin errors++; $display("FAIL early_new_game got w=%0h go=%0h c=%0d p=%0h r=%0h want 0 0 0 1 1", winner, game_over, move_count, current_player, move_ready); end
    endtask

    task automatic fill_41(output bit any_to);
        int lo, hi, dc; bit to;
        any_to = 1'b0;
        start_new_game();
        for (int m = 0; m < 41; m++) begin
            play_move(2'b00, 2'b00, 0, 1'b0, lo, hi, dc, to);
            if (to) any_to = 1'b1;
        end
    endtask

    task automatic test_draw();
        int lo, hi, dc; bit to, any_to;
        fill_41(any_to);
        checks++; if (any_to !== 1'b0) begin errors++; $display("FAIL draw_fill_timeout got %0h want 0", any_to); end
        checks++; if (move_count !== 6'd41 || game_over !== 1'b0 || current_player !== 2'b10) begin errors++; $display("FAIL draw_41 got c=%0d go=%0h p=%0h want 41 0 2", move_count, game_over, current_player); end
        play_move(2'b00, 2'b00, 0, 1'b0, lo, hi, dc, to);
        checks++; if (draw !== 1'b1 || game_over !== 1'b1) begin errors++; $display("FAIL draw_flags got d=%0h go=%0h want 1 1", draw, game_over); end
        checks++; if (move_count !== 6'd42 || winner !== 2'b00 || move_ready !== 1'b0) begin errors++; $display("FAIL draw_state got c=%0d w=%0h r=%0h want 42 0 0", move_count, winner, move_ready); end
    endtask

    task automatic test_win_last_move();
        int lo, hi, dc; bit to, any_to;
        fill_41(any_to);
        play_move(2'b00, 2'b01, 100, 1'b0, lo, hi, dc, to);
        checks++; if (any_to !== 1'b0 || to !== 1'b0 || hi != 100) begin errors++; $display("FAIL last_scan got to=%0h/%0h hi=%0d want 0 0 100", any_to, to, hi); end
        checks++; if (winner !== 2'b01 || draw !== 1'b0 || game_over !== 1'b1 || move_count !== 6'd42) begin errors++; $display("FAIL last_result got w=%0h d=%0h go=%0h c=%0d want 1 0 1 42", winner, draw, game_over, move_count); end
    endtask

    task automatic test_stall_illegal();
        int lo, hi, dc; bit to;
        start_new_game();
        play_move(2'b11, 2'b00, 0, 1'b1, lo, hi, dc, to);
        checks++; if (to !== 1'b0 || lo != 2 || hi != 228) begin errors++; $display("FAIL stall_timing got to=%0h lo=%0d hi=%0d want 0 2 228", to, lo, hi); end
        checks++; if (move_count !== 6'd1) begin errors++; $display("FAIL stall_count got %0d want 1", move_count); end
        checks++; if (current_player !== 2'b10 || winner !== 2'b00 || game_over !== 1'b0) begin errors++; $display("FAIL illegal_result got p=%0h w=%0h go=%0h want 2 0 0", current_player, winner, game_over); end
    endtask

    task automatic test_back_to_back();
        int lo, hi, dc; bit to;
        play_move(2'b00, 2'b00, 0, 1'b0, lo, hi, dc, to);
        checks++; if (to !== 1'b0 || move_count !== 6'd2 || current_player !== 2'b01) begin errors++; $display("FAIL b2b_second got to=%0h c=%0d p=%0h want 0 2 1", to, move_count, current_player); end
        new_game = 1'b1; move_valid = 1'b1;
        @(negedge clock);
        new_game = 1'b0; move_valid = 1'b0;
        checks++; if (move_count !== 6'd0 || busy !== 1'b0 || current_player !== 2'b01) begin errors++; $display("FAIL newgame_vs_move got c=%0d b=%0h p=%0h want 0 0 1", move_count, busy, current_player); end
    endtask

    task automatic test_reset_mid_scan();
        int lo, hi, dc; bit to;
        start_new_game();
        play_move(2'b00, 2'b00, 0, 1'b0, lo, hi, dc, to);
        move_valid = 1'b1;
        @(negedge clock);
        move_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 300 && hi < 100; i++) begin
            @(negedge clock);
            if (rec_enable) hi++;
        end
        checks++; if (hi != 100 || move_count !== 6'd2) begin errors++; $display("FAIL midscan_reach got hi=%0d c=%0d want 100 2", hi, move_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rec_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midscan_reset_en got en=%0h b=%0h want 0 0", rec_enable, busy); end
        checks++; if (current_player !== 2'b01 || move_count !== 6'd0) begin errors++; $display("FAIL midscan_reset_regs got p=%0h c=%0d want 1 0", current_player, move_count); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (move_ready !== 1'b1 || rec_enable !== 1'b0) begin errors++; $display("FAIL midscan_release got r=%0h en=%0h want 1 0", move_ready, rec_enable); end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_early_win();
        test_stall_illegal();
        test_back_to_back();
        test_reset_mid_scan();
        test_draw();
        test_win_last_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/win_check_controller.md
Name: win_check_controller

Overview:
- Turn and win-check sequencer for the Connect-4 game core.
- Accepts one move at a time from the move-entry logic and starts a win check for it.
- Runs each check by driving the enable of the 2-bit sequence recognizer, which scans the 452-bit combos vector.
- Interprets the recognizer result, tracks the current player, move count, winner and draw, and stalls new moves until the check completes.

Parameters:
- COMBO_BITS, 452: width of the combos vector scanned by the recognizer (2 bits per cell).
- LOAD_CYCLES, 2: cycles rec_enable is held low before a scan, so the recognizer reloads its shifter and resets its FSM.
- SCAN_CYCLES, COMBO_BITS/2 + 2 (= 228): cycles rec_enable is held high. Covers all pieces plus 2 cycles of recognizer pipeline latency.
- MAX_MOVES, 42: board cells (7x6); reaching this count without a win is a draw.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- new_game, input, 1: synchronous clear to the post-reset state; ignored while reset is high.
- move_valid, input, 1: move-entry logic has written a piece into the board and combos is updated.
- move_ready, output, 1: the controller can accept a move; a move is accepted when move_valid and move_ready are both high on an edge.
- rec_enable, output, 1: drives the enable input of the sequence recognizer.
- rec_out, input, 2: recognizer result. 00 = none, 01 = red four, 10 = yellow four, 11 = illegal.
- current_player, output, 2: player to move; 01 red, 10 yellow.
- winner, output, 2: 00 none, 01 red, 10 yellow.
- game_over, output, 1: a win or a draw has been declared.
- draw, output, 1: board full with no win.
- move_count, output, 6: number of accepted moves, 0..MAX_MOVES.
- busy, output, 1: a check is in progress (state is LOAD, SCAN or DECIDE).

Behaviour:
- Reset and new_game values:
  - State IDLE, rec_enable = 0, current_player = 01, winner = 00, game_over = 0, draw = 0, move_count = 0, scan counter = 0.
  - reset takes effect asynchronously, including mid-scan.
  - new_game takes effect on the next edge from any state.
- States: IDLE, LOAD, SCAN, DECIDE, OVER.
- IDLE:
  - move_ready = 1, rec_enable = 0.
  - On an accepted move: move_count increments and the state goes to LOAD. Counter loads LOAD_CYCLES-1.
  - move_valid while move_ready = 0 is ignored, not queued.
- LOAD:
  - rec_enable = 0.
  - Counter decrements; at 0 the state goes to SCAN and the counter loads SCAN_CYCLES-1.
- SCAN:
  - rec_enable = 1.
  - If rec_out is 01 or 10 on an edge, go to DECIDE immediately (early exit; recognizer win states are sticky).
  - Otherwise decrement; at 0 go to DECIDE.
- DECIDE:
  - rec_enable = 0. rec_out is still valid this cycle because the recognizer's state register updates only at the next edge.
  - If rec_out = 01 or 10: winner = rec_out, game_over = 1, go to OVER.
  - Else if move_count = MAX_MOVES: draw = 1, game_over = 1, go to OVER.
  - Else: current_player toggles (01 <-> 10), go to IDLE.
  - rec_out = 11 is treated as 00.
- OVER:
  - move_ready = 0, rec_enable = 0.
  - Outputs hold until new_game or reset.
- busy = 1 exactly in LOAD, SCAN and DECIDE. move_ready = 1 exactly in IDLE and not game_over.
- Latency:
  - Accept to DECIDE with no early exit: LOAD_CYCLES + SCAN_CYCLES cycles.
  - Result outputs update on the edge leaving DECIDE.
  - Minimum accept-to-accept spacing with no win: LOAD_CYCLES + SCAN_CYCLES + 2 cycles.
- move_count saturates at MAX_MOVES.
- The scan counter is 8 bits and never wraps within a scan.
- new_game and move_valid on the same edge: new_game wins; the move is dropped.
- Winner takes precedence over draw when the 42nd move completes a four.

Decomposition:
- Shared package game_pkg holds:
  - Piece codes EMPTY = 2'b00, RED = 2'b01, YELLOW = 2'b10.
  - COMBO_BITS and MAX_MOVES.
  - The controller state encoding.
- The recognizer and its piece-code state machine also use game_pkg piece codes.
- A single sub-module, cycle_timer, is natural: loadable 8-bit down-counter with a done flag, used for both the LOAD and SCAN phases.
- The FSM and game registers stay in the top-level module.

Test Plan:
- Reset mid-SCAN (counter = 100):
  - reset high asynchronously gives rec_enable = 0, state IDLE, current_player = 01 and move_count = 0 before the next edge.
  - move_ready = 1 after release.
- Single move, rec_out held 00:
  - rec_enable is low 2 cycles, then high exactly 228 cycles.
  - current_player goes 01 -> 10, move_count = 1, winner = 00, move_ready returns high.
- Early win:
  - rec_out = 10 on SCAN cycle 37 gives DECIDE on the next cycle.
  - Next edge: winner = 10, game_over = 1, move_ready = 0.
  - A later move_valid has no effect; new_game restores the reset values.
- Draw:
  - 42 accepted moves with rec_out = 00 gives draw = 1, game_over = 1, move_count = 42, winner = 00.
- Win on the 42nd move with rec_out = 01:
  - winner = 01 and draw = 0.
- Stall and illegal code:
  - move_valid pulses during LOAD/SCAN are ignored; move_count increments only once.
  - rec_out = 11 for a full scan is treated as no win; current_player toggles.
